keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000; clk cycles per column dwell, legal values 2 or more.
REQ-002 SHALL have parameter DEB_SCANS, default 10; consecutive agreeing samples required for press or release, legal values 1 to 255.
REQ-003 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port row  input  4  keypad row lines, active-low, asynchronous to clk.
REQ-006 SHALL have port col  output  4  keypad column drive, active-low, one-hot-zero.
REQ-007 SHALL have port key_code  output  4  hex value of the last accepted key.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse when a press is accepted.
REQ-009 SHALL have port key_down  output  1  level; high from press acceptance until release acceptance.
REQ-010 SHALL have port sseg  output  8  active-low segments {dp,g..a} of key_code; present only with KEYPAD_SSEG_EN.

Function
REQ-011 SHALL pass row through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-012 SHALL run a dwell counter 0..SCAN_DIV-1, wrapping; the sample point is count SCAN_DIV-1.
REQ-013 SHALL have FSM states SCAN, DEBOUNCE and HELD; the reset state is SCAN.
REQ-014 In SCAN, col SHALL advance 1110->1101->1011->0111->1110 on each counter wrap.
REQ-015 SCAN: at a sample with any row low, SHALL capture the lowest-index low row plus the current column, set deb_cnt=1 and enter DEBOUNCE; col then freezes.
REQ-016 DEBOUNCE: at each sample, if only the captured row is low in its bit, deb_cnt SHALL increment; on reaching DEB_SCANS it SHALL pulse key_valid, set key_down, load key_code and enter HELD.
REQ-017 DEBOUNCE: captured row high at a sample -> SHALL return to SCAN, deb_cnt=0, no output change; column rotation resumes at the next wrap.
REQ-018 With DEB_SCANS=1, the FSM SHALL go from SCAN directly to HELD at the first sample, with the same outputs as REQ-016.
REQ-019 HELD: captured row high at a sample -> rel_cnt SHALL increment; low -> rel_cnt=0; at DEB_SCANS it SHALL clear key_down and return to SCAN.
REQ-020 key_code SHALL equal KEY_MAP[col][row]: col0 = 1,4,7,0; col1 = 2,5,8,F; col2 = 3,6,9,E; col3 = A,B,C,D (rows 0..3).
REQ-021 key_valid SHALL assert the cycle after the accepting sample, for exactly 1 cycle; key_code SHALL update in the same cycle and hold until the next acceptance.
REQ-022 Other keys pressed while in DEBOUNCE or HELD SHALL be ignored (no rollover).
REQ-023 Counters SHALL saturate, never wrap, within DEB_SCANS.

Reset
REQ-024 On rst: col=1110, key_code=0, key_valid=0, key_down=0, state=SCAN, dwell/deb/rel counters=0, synchronizer=1111.
REQ-025 Reset asserted mid-debounce or mid-hold SHALL abort it with no key_valid pulse; after release, scanning restarts at column 0.

Configuration
REQ-026 Macro KEYPAD_SSEG_EN defined: sseg port present, registered hex-to-seven-segment of key_code, reset value 8'hC0 ("0"), dp=1.
REQ-027 KEYPAD_SSEG_EN undefined: no sseg port and no decode logic; all other behaviour identical.

Structure
REQ-028 Package keypad_pkg SHALL hold the FSM state typedef, the KEY_MAP constant and the seven-segment pattern table.
REQ-029 Hex-to-segment decode SHALL be sub-module hex_to_sseg (combinational, 4 bits in, 8 bits out), instantiated only under KEYPAD_SSEG_EN.

Verification (SCAN_DIV=4, DEB_SCANS=3)
REQ-030 Idle, rows 1111 -> col cycles 1110,1101,1011,0111, each held 4 cycles; key_valid never asserts.
REQ-031 Hold row=1011 while col=1101 -> after 3 samples, a single key_valid pulse with key_code=8 and key_down=1; col stays 1101.
REQ-032 row low for 2 samples, then high -> no key_valid; FSM returns to SCAN; key_code unchanged.
REQ-033 Key 5 held, release glitch of 1 sample high then low -> key_down stays 1; after 3 clean high samples key_down=0 and rotation resumes.
REQ-034 Key 7 (col0,row2) held, then key 2 also pressed -> no second key_valid; key_code stays 7.
REQ-035 rst pulsed at deb_cnt=2 -> all outputs at reset values with no key_valid; with KEYPAD_SSEG_EN, an accepted key A gives sseg=8'h88.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg -- shared types and constant tables for the 4x4 keypad scanner.
//
//   state_t        : scanner FSM states (SCAN, DEBOUNCE, HELD)
//   KEY_MAP        : hex value of each key, indexed [column][row]
//   SSEG_TABLE     : active-low {dp,g,f,e,d,c,b,a} pattern for each hex digit
//   low_row_index  : index of the lowest-numbered active-low row line
//
// Used by keypad_scan (top) and hex_to_sseg (optional KEYPAD_SSEG_EN decoder).
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    // [column][row]; each inner list runs row 0..3.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h4, 4'h7, 4'h0},
        '{4'h2, 4'h5, 4'h8, 4'hF},
        '{4'h3, 4'h6, 4'h9, 4'hE},
        '{4'hA, 4'hB, 4'hC, 4'hD}
    };

    // Active-low segments, dp kept dark (bit 7 = 1).
    localparam logic [7:0] SSEG_TABLE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Lowest-index row that reads low; only meaningful when some row is low.
    function automatic logic [1:0] low_row_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// hex_to_sseg -- combinational hex digit to seven-segment decoder.
//
// Ports:
//   hex : in  4  digit to display
//   seg : out 8  active-low segments {dp,g,f,e,d,c,b,a}, dp always off
//
// Instantiated by keypad_scan only when KEYPAD_SSEG_EN is defined.
module hex_to_sseg
    import keypad_pkg::*;
(
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    assign seg = SSEG_TABLE[hex];

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan -- 4x4 matrix keypad scanner with debounce and hex output.
//
// Parameters:
//   SCAN_DIV  : clk cycles per column dwell (>= 2)
//   DEB_SCANS : consecutive agreeing samples to accept a press or release (1..255)
//
// Ports:
//   clk       : in  1  system clock, rising edge
//   rst       : in  1  asynchronous active-high reset
//   row       : in  4  keypad rows, active-low, asynchronous to clk
//   col       : out 4  column drive, active-low, one-hot-zero
//   key_code  : out 4  hex value of the last accepted key
//   key_valid : out 1  one-cycle pulse on press acceptance
//   key_down  : out 1  high from press acceptance until release acceptance
//   fsm_state : out 2  current scanner state (debug observation)
//   sseg      : out 8  active-low segments of key_code (only with KEYPAD_SSEG_EN)
//
// Build option: define KEYPAD_SSEG_EN to add the sseg port and its decoder.
//
// Row lines are only looked at once per dwell, at the last count of the
// dwell counter, so the column drive has settled well before the sample.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int DEB_SCANS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output state_t     fsm_state
`ifdef KEYPAD_SSEG_EN
    ,
    output logic [7:0] sseg
`endif
);

    localparam int             DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0]     DEB_LAST = 8'(DEB_SCANS - 1);

    state_t           state, state_next;
    logic [3:0]       row_meta, row_sync;
    logic [DIV_W-1:0] dwell;
    logic [1:0]       col_idx;
    logic [1:0]       cap_row;
    logic [7:0]       deb_cnt, deb_next;
    logic [7:0]       rel_cnt, rel_next;

    logic             sample;
    logic             any_low;
    logic             cap_low;
    logic [1:0]       new_row;
    logic             capture, accept, release_key, advance;
    logic [1:0]       accept_row;
    logic [3:0]       code_next;

    assign sample    = (dwell == DIV_LAST);
    assign any_low   = ~&row_sync;
    assign cap_low   = ~row_sync[cap_row];
    assign new_row   = low_row_index(row_sync);
    assign col       = ~(4'b0001 << col_idx);
    assign fsm_state = state;

    // With a single-sample debounce the press is accepted straight from SCAN,
    // before cap_row has been loaded, so take the row from the live sample.
    assign accept_row = (state == SCAN) ? new_row : cap_row;
    assign code_next  = KEY_MAP[col_idx][accept_row];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= SCAN;
        else     state <= state_next;
    end

    // Counters only move at sample points; both compare against DEB_LAST
    // before incrementing, so neither can pass DEB_SCANS.
    always_comb begin
        state_next  = state;
        deb_next    = deb_cnt;
        rel_next    = rel_cnt;
        capture     = 1'b0;
        accept      = 1'b0;
        release_key = 1'b0;
        advance     = 1'b0;
        case (state)
            SCAN: begin
                if (sample) begin
                    if (any_low) begin
                        capture  = 1'b1;
                        rel_next = 8'd0;
                        if (DEB_SCANS == 1) begin
                            accept     = 1'b1;
                            deb_next   = 8'd0;
                            state_next = HELD;
                        end else begin
                            deb_next   = 8'd1;
                            state_next = DEBOUNCE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DEBOUNCE: begin
                if (sample) begin
                    if (cap_low) begin
                        if (deb_cnt == DEB_LAST) begin
                            accept     = 1'b1;
                            deb_next   = 8'd0;
                            rel_next   = 8'd0;
                            state_next = HELD;
                        end else begin
                            deb_next = deb_cnt + 8'd1;
                        end
                    end else begin
                        deb_next   = 8'd0;
                        state_next = SCAN;
                    end
                end
            end
            HELD: begin
                if (sample) begin
                    if (!cap_low) begin
                        if (rel_cnt == DEB_LAST) begin
                            release_key = 1'b1;
                            rel_next    = 8'd0;
                            state_next  = SCAN;
                        end else begin
                            rel_next = rel_cnt + 8'd1;
                        end
                    end else begin
                        rel_next = 8'd0;
                    end
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            dwell     <= '0;
            col_idx   <= 2'd0;
            cap_row   <= 2'd0;
            deb_cnt   <= 8'd0;
            rel_cnt   <= 8'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            row_meta  <= row;
            row_sync  <= row_meta;
            dwell     <= sample ? '0 : dwell + 1'b1;
            deb_cnt   <= deb_next;
            rel_cnt   <= rel_next;
            key_valid <= accept;
            if (advance) col_idx <= col_idx + 2'd1;
            if (capture) cap_row <= new_row;
            if (accept) begin
                key_code <= code_next;
                key_down <= 1'b1;
            end else if (release_key) begin
                key_down <= 1'b0;
            end
        end
    end

`ifdef KEYPAD_SSEG_EN
    logic [7:0] seg_next;

    // Decode the code being loaded so sseg changes in the same cycle as key_code.
    hex_to_sseg u_hex_to_sseg (
        .hex (code_next),
        .seg (seg_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         sseg <= 8'hC0;
        else if (accept) sseg <= seg_next;
    end
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan -- self-checking bench for keypad_scan (SCAN_DIV=4, DEB_SCANS=3).
// A behavioural keypad pulls row lines low for pressed keys in the driven column.
// Press acceptances are pushed into exp_q; a negedge monitor pops and compares
// whenever key_valid is seen.
module tb_keypad_scan;
    import keypad_pkg::*;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 3;

    logic       clk;
    logic       rst;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    state_t     fsm_state;
`ifdef KEYPAD_SSEG_EN
    logic [7:0] sseg;
`endif

    // pressed[c*4 + r] = key at column c, row r is held down
    logic [15:0] pressed;

    int checks;
    int errors;
    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;

    keypad_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .DEB_SCANS (DEB_SCANS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .fsm_state (fsm_state)
`ifdef KEYPAD_SSEG_EN
        ,
        .sseg      (sseg)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- keypad model ----------------
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col[c] && pressed[c*4 + r]) row[r] = 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (key_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_key_valid: key_code=%0h, no press expected", key_code);
            end else begin
                mon_exp = exp_q.pop_front();
                checks++;
                if (key_code !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_key_code: got %0h expected %0h", key_code, mon_exp);
                end
                checks++;
                if (key_down !== 1'b1) begin
                    errors++;
                    $display("FAIL sb_key_down: got %0b expected 1", key_down);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    task automatic wait_negs(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input state_t s, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fsm_state !== s && n < 300);
        if (fsm_state !== s) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, state=%0d expected %0d", name, fsm_state, s);
        end
    endtask

    task automatic wait_key_valid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (key_valid !== 1'b1 && n < 300);
        if (key_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, key_valid=%0b expected 1", name, key_valid);
        end
    endtask

    task automatic wait_key_up(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (key_down !== 1'b0 && n < 300);
        if (key_down !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, key_down=%0b expected 0", name, key_down);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] ec;
        checks  = 0;
        errors  = 0;
        pressed = 16'h0000;
        rst     = 1'b1;
        wait_negs(3);

        // Reset values
        check("rst_col",       32'(col),       32'(4'b1110));
        check("rst_key_code",  32'(key_code),  32'(4'h0));
        check("rst_key_valid", 32'(key_valid), 32'(1'b0));
        check("rst_key_down",  32'(key_down),  32'(1'b0));
        check("rst_state",     32'(fsm_state), 32'(SCAN));
`ifdef KEYPAD_SSEG_EN
        check("rst_sseg",      32'(sseg),      32'(8'hC0));
`endif

        // Idle rotation: each column held SCAN_DIV cycles
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ec = ~(4'b0001 << (k / 4));
            check("idle_col", 32'(col), 32'(ec));
            @(negedge clk);
        end

        // Key 8 (col1,row2): accepted exactly 8 cycles after capture
        pressed[1*4 + 2] = 1'b1;
        exp_q.push_back(4'h8);
        wait_state(DEBOUNCE, "k8_wait_debounce");
        check("k8_col_frozen", 32'(col), 32'(4'b1101));
        wait_negs(7);
        check("k8_no_early_valid", 32'(key_valid), 32'(1'b0));
        wait_negs(1);
        check("k8_valid", 32'(key_valid), 32'(1'b1));
        check("k8_col_held", 32'(col), 32'(4'b1101));
        check("k8_state", 32'(fsm_state), 32'(HELD));
        wait_negs(1);
        check("k8_pulse_width", 32'(key_valid), 32'(1'b0));
        check("k8_code_hold", 32'(key_code), 32'(4'h8));
        pressed = 16'h0000;
        wait_key_up("k8_release");
        check("k8_back_to_scan", 32'(fsm_state), 32'(SCAN));

        // Key 6 low for only 2 samples: aborted, nothing changes
        pressed[2*4 + 1] = 1'b1;
        wait_state(DEBOUNCE, "short_wait_debounce");
        wait_negs(4);
        pressed = 16'h0000;
        wait_negs(8);
        check("short_state", 32'(fsm_state), 32'(SCAN));
        check("short_key_code", 32'(key_code), 32'(4'h8));
        check("short_key_down", 32'(key_down), 32'(1'b0));

        // Key 5 with a one-sample release glitch
        pressed[1*4 + 1] = 1'b1;
        exp_q.push_back(4'h5);
        wait_key_valid("k5_wait_valid");
        pressed = 16'h0000;         // sample +4 sees high
        wait_negs(4);
        pressed[1*4 + 1] = 1'b1;    // sample +8 sees low again
        wait_negs(4);
        pressed = 16'h0000;         // clean release from sample +12
        wait_negs(8);
        check("k5_glitch_down", 32'(key_down), 32'(1'b1));
        check("k5_glitch_state", 32'(fsm_state), 32'(HELD));
        wait_negs(4);
        check("k5_released", 32'(key_down), 32'(1'b0));
        check("k5_rel_state", 32'(fsm_state), 32'(SCAN));
        check("k5_rel_col", 32'(col), 32'(4'b1101));
        wait_negs(4);
        check("k5_rotation_resumes", 32'(col), 32'(4'b1011));

        // Key 7 held, then keys 2 and 1 added: ignored
        pressed[0*4 + 2] = 1'b1;
        exp_q.push_back(4'h7);
        wait_key_valid("k7_wait_valid");
        pressed[1*4 + 0] = 1'b1;
        pressed[0*4 + 0] = 1'b1;
        wait_negs(40);
        check("k7_code_kept", 32'(key_code), 32'(4'h7));
        check("k7_down_kept", 32'(key_down), 32'(1'b1));
        check("k7_col_frozen", 32'(col), 32'(4'b1110));
        check("k7_state", 32'(fsm_state), 32'(HELD));
        pressed = 16'h0000;
        wait_key_up("k7_release");

        // Reset in the middle of debouncing key A (deb_cnt = 2)
        pressed[3*4 + 0] = 1'b1;
        wait_state(DEBOUNCE, "ka_wait_debounce");
        wait_negs(4);
        rst = 1'b1;
        wait_negs(1);
        check("mid_rst_col", 32'(col), 32'(4'b1110));
        check("mid_rst_key_code", 32'(key_code), 32'(4'h0));
        check("mid_rst_key_valid", 32'(key_valid), 32'(1'b0));
        check("mid_rst_key_down", 32'(key_down), 32'(1'b0));
        check("mid_rst_state", 32'(fsm_state), 32'(SCAN));
`ifdef KEYPAD_SSEG_EN
        check("mid_rst_sseg", 32'(sseg), 32'(8'hC0));
`endif
        pressed = 16'h0000;
        wait_negs(1);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ec = ~(4'b0001 << (k / 4));
            check("restart_col", 32'(col), 32'(ec));
            @(negedge clk);
        end

        // Key A accepted cleanly
        pressed[3*4 + 0] = 1'b1;
        exp_q.push_back(4'hA);
        wait_key_valid("ka_wait_valid");
        check("ka_key_code", 32'(key_code), 32'(4'hA));
`ifdef KEYPAD_SSEG_EN
        check("ka_sseg", 32'(sseg), 32'(8'h88));
`endif
        pressed = 16'h0000;
        wait_key_up("ka_release");
        wait_negs(4);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending presses expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
